multi_motor_cntrl: RTL and testbench

MULTI_MOTOR_CNTRL -- requirements
Module: multi_motor_cntrl

---
 rtl/mc_pkg.sv | 17 +
 rtl/mc_channel.sv | 116 +++++++++++
 rtl/multi_motor_cntrl.sv | 58 +++++
 tb/tb_multi_motor_cntrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared drive-state encoding and default sizing for the multi-channel H-bridge controller.
// Default values describe a 2-channel, 11-bit command, 1024-clock PWM configuration.
package mc_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } mc_state_e;

  localparam int NUM_CH_DEF    = 2;
  localparam int CMD_W_DEF     = 11;
  localparam int RAMP_STEP_DEF = 16;
  localparam int DEADTIME_DEF  = 8;

endpackage

// File: rtl/mc_channel.sv
// One H-bridge channel: slew-limited applied command, PWM duty, dead-time FSM, registered pins.
// Pins follow the shared counter and drive state by one clock.
module mc_channel
  import mc_pkg::*;
#(
  parameter int CMD_W     = CMD_W_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int DEADTIME  = DEADTIME_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CMD_W-2:0]        i_cnt,
  input  logic                    i_tick,
  input  logic signed [CMD_W-1:0] i_tgt,
  input  logic                    i_coast,
  output logic                    o_fwd,
  output logic                    o_rev,
  output logic                    o_at_target
);

  localparam int PWM_W = CMD_W - 1;
  localparam int DC_W  = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic signed [CMD_W:0] STEP = (CMD_W+1)'(RAMP_STEP);

  logic signed [CMD_W-1:0] r_cur;
  logic signed [CMD_W-1:0] w_cur_nxt;
  logic signed [CMD_W:0]   w_cur_x, w_tgt_x, w_up, w_dn;
  logic [CMD_W-1:0]        w_neg;
  logic [PWM_W-1:0]        w_duty;
  logic                    w_pwm;
  mc_state_e               r_state, w_state_nxt, w_desired;
  logic [DC_W-1:0]         r_dcnt, w_dcnt_nxt;
  logic                    r_fwd, r_rev, r_at;
  logic                    w_fwd_nxt, w_rev_nxt;

  // Ramp in one extra bit so cur+/-STEP cannot wrap before the clamp.
  assign w_cur_x = {r_cur[CMD_W-1], r_cur};
  assign w_tgt_x = {i_tgt[CMD_W-1], i_tgt};
  assign w_up    = w_cur_x + STEP;
  assign w_dn    = w_cur_x - STEP;

  always_comb begin
    w_cur_nxt = r_cur;
    if (w_tgt_x > w_cur_x)
      w_cur_nxt = (w_up > w_tgt_x) ? i_tgt : w_up[CMD_W-1:0];
    else if (w_tgt_x < w_cur_x)
      w_cur_nxt = (w_dn < w_tgt_x) ? i_tgt : w_dn[CMD_W-1:0];
  end

  // Negating the most negative command leaves its sign bit set: saturate that case.
  assign w_neg  = -r_cur;
  assign w_duty = !r_cur[CMD_W-1] ? r_cur[PWM_W-1:0] :
                  (w_neg[CMD_W-1] ? '1 : w_neg[PWM_W-1:0]);
  assign w_pwm  = (i_cnt < w_duty);

  always_comb begin
    w_desired = ST_FWD;
    if (r_cur == '0)
      w_desired = ST_STOP;
    else if (r_cur[CMD_W-1])
      w_desired = ST_REV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur   <= '0;
      r_state <= ST_STOP;
      r_dcnt  <= '0;
      r_fwd   <= 1'b0;
      r_rev   <= 1'b0;
      r_at    <= 1'b0;
    end else begin
      if (i_tick)
        r_cur <= w_cur_nxt;
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_fwd   <= w_fwd_nxt;
      r_rev   <= w_rev_nxt;
      r_at    <= (r_cur == i_tgt);
    end
  end

  // DEAD exits on a fixed count; the destination is whatever is desired at exit.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = '0;
    w_fwd_nxt   = 1'b0;
    w_rev_nxt   = 1'b0;
    case (r_state)
      ST_DEAD: begin
        if (r_dcnt == DC_W'(DEADTIME - 1))
          w_state_nxt = w_desired;
        else
          w_dcnt_nxt = r_dcnt + 1'b1;
      end
      default: begin
        if (w_desired != r_state)
          w_state_nxt = ST_DEAD;
      end
    endcase
    case (r_state)
      ST_STOP: begin
        w_fwd_nxt = ~i_coast;
        w_rev_nxt = ~i_coast;
      end
      ST_FWD:  w_fwd_nxt = w_pwm;
      ST_REV:  w_rev_nxt = w_pwm;
      default: ;
    endcase
  end

  assign o_fwd       = r_fwd;
  assign o_rev       = r_rev;
  assign o_at_target = r_at;

endmodule

// File: rtl/multi_motor_cntrl.sv
// Multi-channel H-bridge PWM controller: shared free-running counter plus one mc_channel per motor.
// Bridge pins are registered; period_tick is decoded from the counter in the same clock.
module multi_motor_cntrl
  import mc_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int CMD_W     = CMD_W_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int DEADTIME  = DEADTIME_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH*CMD_W-1:0] cmd,
  input  logic [NUM_CH-1:0]       coast,
  output logic [NUM_CH-1:0]       fwd,
  output logic [NUM_CH-1:0]       rev,
  output logic                    period_tick,
  output logic [NUM_CH-1:0]       at_target
);

  localparam int PWM_W = CMD_W - 1;

  logic [PWM_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign period_tick = &r_cnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic signed [CMD_W-1:0] w_tgt;

    // Dropping en zeroes the target only, so the channel still ramps down.
    assign w_tgt = en ? cmd[i*CMD_W +: CMD_W] : '0;

    mc_channel #(
      .CMD_W     (CMD_W),
      .RAMP_STEP (RAMP_STEP),
      .DEADTIME  (DEADTIME)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_cnt       (r_cnt),
      .i_tick      (period_tick),
      .i_tgt       (w_tgt),
      .i_coast     (coast[i]),
      .o_fwd       (fwd[i]),
      .o_rev       (rev[i]),
      .o_at_target (at_target[i])
    );
  end

endmodule

// File: tb/tb_multi_motor_cntrl.sv
// Bench for multi_motor_cntrl: per-cycle comparison against a behavioural model plus directed checks.
module tb_multi_motor_cntrl;

  localparam int NCH  = 2;
  localparam int CW   = 11;
  localparam int STEP = 64;
  localparam int DT   = 8;
  localparam int PER  = 1024;
  localparam int DMAX = 1023;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en  = 1'b1;
  logic [NCH*CW-1:0]   cmd = '0;
  logic [NCH-1:0]      coast = '0;
  logic [NCH-1:0]      fwd, rev, at_target;
  logic                period_tick;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  multi_motor_cntrl #(
    .NUM_CH    (NCH),
    .CMD_W     (CW),
    .RAMP_STEP (STEP),
    .DEADTIME  (DT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cmd         (cmd),
    .coast       (coast),
    .fwd         (fwd),
    .rev         (rev),
    .period_tick (period_tick),
    .at_target   (at_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cmd_of(input int ch);
    logic signed [CW-1:0] v;
    v = cmd[ch*CW +: CW];
    return int'(v);
  endfunction

  task automatic set_cmd(input int ch, input int v);
    cmd[ch*CW +: CW] = CW'(v);
  endtask

  // Behavioural model: integer applied command, drive mode -1/0/+1, dead-time clocks remaining.
  int m_cnt;
  int m_cur  [NCH];
  int m_mode [NCH];
  int m_dead [NCH];
  bit [NCH-1:0] e_fwd, e_rev, e_at;
  int t_tgt, t_mag, t_want;
  bit t_on;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      for (int c = 0; c < NCH; c++) begin
        m_cur[c] = 0; m_mode[c] = 0; m_dead[c] = 0;
      end
      e_fwd = '0; e_rev = '0; e_at = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        t_tgt = en ? cmd_of(c) : 0;
        t_mag = (m_cur[c] < 0) ? -m_cur[c] : m_cur[c];
        if (t_mag > DMAX) t_mag = DMAX;
        t_on = (m_cnt < t_mag);
        if (m_dead[c] > 0) begin
          e_fwd[c] = 1'b0; e_rev[c] = 1'b0;
        end else if (m_mode[c] == 0) begin
          e_fwd[c] = ~coast[c]; e_rev[c] = ~coast[c];
        end else if (m_mode[c] > 0) begin
          e_fwd[c] = t_on; e_rev[c] = 1'b0;
        end else begin
          e_fwd[c] = 1'b0; e_rev[c] = t_on;
        end
        t_want = (m_cur[c] > 0) ? 1 : ((m_cur[c] < 0) ? -1 : 0);
        if (m_dead[c] > 0) begin
          m_dead[c]--;
          if (m_dead[c] == 0) m_mode[c] = t_want;
        end else if (t_want != m_mode[c]) begin
          m_dead[c] = DT;
        end
        e_at[c] = (m_cur[c] == t_tgt);
        if (m_cnt == PER - 1) begin
          if (t_tgt > m_cur[c])
            m_cur[c] = (m_cur[c] + STEP > t_tgt) ? t_tgt : m_cur[c] + STEP;
          else if (t_tgt < m_cur[c])
            m_cur[c] = (m_cur[c] - STEP < t_tgt) ? t_tgt : m_cur[c] - STEP;
        end
      end
      m_cnt = (m_cnt + 1) % PER;
    end
  end

  logic [NCH-1:0] p_fwd = '0, p_rev = '0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("fwd", int'(fwd), int'(e_fwd));
      chk("rev", int'(rev), int'(e_rev));
      chk("period_tick", int'(period_tick), int'(m_cnt == PER - 1));
      chk("at_target", int'(at_target), int'(e_at));
      for (int c = 0; c < NCH; c++)
        chk("overlap", int'((p_fwd[c] & ~p_rev[c] & rev[c] & ~fwd[c]) |
                            (p_rev[c] & ~p_fwd[c] & fwd[c] & ~rev[c])), 0);
      p_fwd = fwd;
      p_rev = rev;
    end
  end

  task automatic wait_tick();
    for (int k = 0; k < PER + 8; k++) begin
      @(negedge clk);
      if (period_tick) break;
    end
    chk("tick_wait", int'(period_tick), 1);
  endtask

  // Starting on a tick cycle, the next PER samples cover exactly one period at the new command.
  task automatic count_period(output int f0, output int r0, output int f1, output int r1);
    f0 = 0; r0 = 0; f1 = 0; r1 = 0;
    repeat (PER) begin
      @(negedge clk);
      f0 += int'(fwd[0]); r0 += int'(rev[0]);
      f1 += int'(fwd[1]); r1 += int'(rev[1]);
    end
  endtask

  initial begin
    int f0, r0, f1, r1, k;
    #1 rst = 1'b1;
    #2 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_fwd", int'(fwd), 0);
    chk("rst_rev", int'(rev), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_at", int'(at_target), 0);
    rst = 1'b0;

    repeat (2) @(negedge clk);
    chk("brake_fwd", int'(fwd), 3);
    chk("brake_rev", int'(rev), 3);
    coast = 2'b01;
    @(negedge clk);
    chk("coast_fwd", int'(fwd), 2);
    chk("coast_rev", int'(rev), 2);

    coast = 2'b11;
    set_cmd(0, 256);
    set_cmd(1, -1024);
    wait_tick();
    wait_tick();
    count_period(f0, r0, f1, r1);
    chk("ramp_128", f0, 128);
    count_period(f0, r0, f1, r1);
    chk("ramp_192", f0, 192);
    chk("at0_before", int'(at_target[0]), 0);
    count_period(f0, r0, f1, r1);
    chk("ramp_256", f0, 256);
    chk("at0_after", int'(at_target[0]), 1);

    set_cmd(0, 64);
    wait_tick();
    wait_tick();
    count_period(f0, r0, f1, r1);
    chk("fwd_64", f0, 64);
    set_cmd(0, -64);
    count_period(f0, r0, f1, r1);
    chk("zero_fwd", f0, 0);
    chk("zero_rev", r0, 0);
    count_period(f0, r0, f1, r1);
    chk("rev_entry", r0, 55);
    count_period(f0, r0, f1, r1);
    chk("rev_64", r0, 64);
    chk("rev_64_fwd", f0, 0);

    set_cmd(0, 512);
    for (int t = 0; t < 24; t++) begin
      wait_tick();
      if (at_target == 2'b11) break;
    end
    chk("settle", int'(at_target), 3);
    count_period(f0, r0, f1, r1);
    chk("fwd_512", f0, 512);
    chk("ch0_rev_off", r0, 0);
    chk("rev_1023", r1, 1023);
    chk("ch1_fwd_off", f1, 0);

    en = 1'b0;
    coast = 2'b00;
    count_period(f0, r0, f1, r1);
    chk("en_off_448", f0, 448);
    repeat (6) wait_tick();
    repeat (30) @(negedge clk);
    chk("stop_fwd", int'(fwd), 1);
    chk("stop_rev", int'(rev), 3);

    #2 rst = 1'b1;
    #1;
    chk("async_fwd", int'(fwd), 0);
    chk("async_rev", int'(rev), 0);
    chk("async_tick", int'(period_tick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (k = 1; k <= PER + 8; k++) begin
      @(negedge clk);
      if (period_tick) break;
    end
    chk("restart", k, PER - 1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
